ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage; receiving end of the decode-stage pipeline interface.
- Consumes the registered decode bundle (opcode, operands, destination, immediate, control bits) and performs ALU / address / branch computation.
- Registers results toward MEM and returns a branch redirect to IF.
- Owns the branch-shadow squash and HALT latch state.

Parameters:
- D_SIZE, 32: datapath width.
- ADDR_LINE_REG, 5: register-address width.
- BRANCH_SHADOW, 1: wrong-path instructions squashed after a taken branch; legal range 0..3.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc4_in_f_id  in  32  PC+4 of the instruction.
- opcode_f_id  in  6  opcode.
- rs_reg_value_f_id  in  D_SIZE  rs operand.
- rt_reg_value_f_id  in  D_SIZE  rt operand; 0 for ALU-immediate ops.
- rd_add_value_f_id  in  ADDR_LINE_REG  destination register.
- i_data_f_id  in  D_SIZE  sign-extended immediate.
- branch_f_id, mem_read_f_id, mem_to_reg_f_id, mem_write_f_id  in  1 each  decode control bits.
- alu_result_2_mem  out  D_SIZE  ALU result or memory address.
- store_data_2_mem  out  D_SIZE  rt value for STW.
- rd_add_2_mem  out  ADDR_LINE_REG  destination register.
- reg_write_2_mem, mem_read_2_mem, mem_write_2_mem  out  1 each  MEM/WB controls.
- halt_2_mem  out  1  HALT reached, sticky.
- branch_taken_2_if  out  1  one-cycle redirect pulse.
- branch_target_2_if  out  32  redirect PC.
- retired_cnt  out  32  valid (non-squashed) instructions executed.
- taken_cnt  out  32  taken branches.

Behaviour:
- Reset: every output is 0, state=RUN, shadow counter=0. Assertion is asynchronous; release is synchronous to clk.
- Latency: 1 cycle. Inputs sampled at edge N appear on *_2_mem / *_2_if after edge N.
- Opcode semantics:
  - ALU, all mod 2^D_SIZE:
    - 00 ADD rs+rt; 01 ADDI rs+imm.
    - 02 SUB rs-rt; 03 SUBI rs-imm.
    - 04 MUL low D_SIZE bits of rs*rt; 05 MULI rs*imm.
    - 06/07 OR / ORI; 08/09 AND / ANDI; 0A/0B XOR / XORI (register forms use rt, immediate forms use imm).
  - Memory:
    - 0C LDW: alu_result = rs+imm.
    - 0D STW: alu_result = rs+imm, store_data = rt.
  - Branches:
    - 0E BZ: taken iff rs==0, target = pc4 + (imm<<2).
    - 0F BEQ: taken iff rs==rt, target = pc4 + (imm<<2).
    - 10 JR: always taken, target = rs.
  - 11 HALT; 3F NOP and undefined opcodes: bubble.
- Controls pass through: reg_write = mem_to_reg_f_id; mem_read and mem_write pass directly.
- store_data_2_mem = rt for every valid instruction; it is meaningful only with mem_write.
- Bubble: reg_write, mem_read, mem_write, branch_taken all 0; alu_result, store_data, rd_add all 0.
- Non-branch cycles: branch_target_2_if holds its previous value.
- State machine:
  - RUN: execute normally.
    - Taken branch -> SQUASH with counter = BRANCH_SHADOW. If BRANCH_SHADOW=0, stay in RUN.
    - HALT -> HALTED.
  - SQUASH: each input is converted to a bubble and the counter decrements; at 0 -> RUN.
    - A branch or HALT arriving in the shadow is squashed: not evaluated, not counted.
  - HALTED: halt_2_mem=1 sticky; all further inputs become bubbles. Exit only by reset.
- HALT itself is a bubble on MEM controls; halt_2_mem rises in the same cycle its result would appear.
- branch_taken_2_if is high for exactly one cycle per taken branch. A not-taken branch is counted as retired, with no pulse.
- Reset asserted mid-squash or while HALTED: immediate return to RUN, all outputs 0.

Optional Feature:
- EX_PERF_CNT_EN defined:
  - retired_cnt increments by 1 per non-squashed, non-bubble instruction, HALT included; NOP and undefined opcodes are excluded.
  - taken_cnt increments per taken branch.
  - Both counters wrap at 2^32 and reset to 0.
- EX_PERF_CNT_EN undefined: no counter flops; retired_cnt and taken_cnt tied to 0.

Test Plan:
- ADD rs=0xFFFFFFFF, rt=2, rd=5, mem_to_reg=1 -> next cycle alu_result=0x00000001, rd_add=5, reg_write=1.
- MULI rs=0x00010000, imm=0xFFFFFFFF (-1) -> alu_result=0xFFFF0000; STW rs=0x100, imm=8, rt=0xAB -> alu_result=0x108, store_data=0xAB, mem_write=1.
- BEQ rs=rt=7, pc4=0x40, imm=3 with BRANCH_SHADOW=1 -> branch_taken pulse, target=0x4C. The following ADD is squashed (all controls 0); the ADD after it executes normally.
- BZ rs=1 -> no pulse, no squash. Then JR rs=0x200 followed by HALT in the shadow -> target=0x200, HALT squashed, halt_2_mem stays 0.
- HALT in RUN followed by ADD/STW -> halt_2_mem=1 sticky, MEM controls 0. Assert reset -> all outputs 0; ADD after release executes.
- With EX_PERF_CNT_EN: ADD, BEQ taken, squashed SUB, NOP, HALT -> retired_cnt=3, taken_cnt=1. Without the macro both counters read 0.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage
// Execute stage: ALU/address/branch evaluation, branch-shadow squash and
// sticky HALT. Define EX_PERF_CNT_EN to enable retired/taken counters.
// Rev     : 1.0
// ============================================================================
module ex_stage #(
    parameter int D_SIZE        = 32,
    parameter int ADDR_LINE_REG = 5,
    parameter int BRANCH_SHADOW = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc4_in_f_id,
    input  logic [5:0]               opcode_f_id,
    input  logic [D_SIZE-1:0]        rs_reg_value_f_id,
    input  logic [D_SIZE-1:0]        rt_reg_value_f_id,
    input  logic [ADDR_LINE_REG-1:0] rd_add_value_f_id,
    input  logic [D_SIZE-1:0]        i_data_f_id,
    input  logic                     branch_f_id,
    input  logic                     mem_read_f_id,
    input  logic                     mem_to_reg_f_id,
    input  logic                     mem_write_f_id,
    output logic [D_SIZE-1:0]        alu_result_2_mem,
    output logic [D_SIZE-1:0]        store_data_2_mem,
    output logic [ADDR_LINE_REG-1:0] rd_add_2_mem,
    output logic                     reg_write_2_mem,
    output logic                     mem_read_2_mem,
    output logic                     mem_write_2_mem,
    output logic                     halt_2_mem,
    output logic                     branch_taken_2_if,
    output logic [31:0]              branch_target_2_if,
    output logic [31:0]              retired_cnt,
    output logic [31:0]              taken_cnt
);

    localparam logic [5:0] c_OP_ADD  = 6'h00;
    localparam logic [5:0] c_OP_ADDI = 6'h01;
    localparam logic [5:0] c_OP_SUB  = 6'h02;
    localparam logic [5:0] c_OP_SUBI = 6'h03;
    localparam logic [5:0] c_OP_MUL  = 6'h04;
    localparam logic [5:0] c_OP_MULI = 6'h05;
    localparam logic [5:0] c_OP_OR   = 6'h06;
    localparam logic [5:0] c_OP_ORI  = 6'h07;
    localparam logic [5:0] c_OP_AND  = 6'h08;
    localparam logic [5:0] c_OP_ANDI = 6'h09;
    localparam logic [5:0] c_OP_XOR  = 6'h0A;
    localparam logic [5:0] c_OP_XORI = 6'h0B;
    localparam logic [5:0] c_OP_LDW  = 6'h0C;
    localparam logic [5:0] c_OP_STW  = 6'h0D;
    localparam logic [5:0] c_OP_BZ   = 6'h0E;
    localparam logic [5:0] c_OP_BEQ  = 6'h0F;
    localparam logic [5:0] c_OP_JR   = 6'h10;
    localparam logic [5:0] c_OP_HALT = 6'h11;

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_SQUASH = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam logic [1:0] c_SHADOW = 2'(BRANCH_SHADOW);

    logic [1:0]               r_state;
    logic [1:0]               r_shadow_cnt;
    logic [1:0]               w_state_nxt;
    logic [1:0]               w_shadow_nxt;

    logic [D_SIZE-1:0]        r_alu_result;
    logic [D_SIZE-1:0]        r_store_data;
    logic [ADDR_LINE_REG-1:0] r_rd_add;
    logic                     r_reg_write;
    logic                     r_mem_read;
    logic                     r_mem_write;
    logic                     r_halt;
    logic                     r_branch_taken;
    logic [31:0]              r_branch_target;

    logic                     w_in_shadow;
    logic                     w_known_op;
    logic                     w_is_halt;
    logic                     w_exec;
    logic                     w_taken_cond;
    logic                     w_taken;
    logic [31:0]              w_imm_ext;
    logic [31:0]              w_target;
    logic [D_SIZE-1:0]        w_alu;
    logic                     w_unused;

    // Branch classification comes from the opcode; the decode flag is redundant.
    assign w_unused = branch_f_id;

    // Anything arriving outside RUN (shadow or halted) is turned into a bubble.
    assign w_in_shadow = (r_state != c_ST_RUN);
    assign w_known_op  = (opcode_f_id <= c_OP_HALT);
    assign w_is_halt   = !w_in_shadow && (opcode_f_id == c_OP_HALT);
    assign w_exec      = !w_in_shadow && w_known_op && (opcode_f_id != c_OP_HALT);
    assign w_imm_ext   = 32'($signed(i_data_f_id));
    assign w_taken     = w_exec && w_taken_cond;

    always_comb begin
        w_alu        = '0;
        w_taken_cond = 1'b0;
        w_target     = pc4_in_f_id + (w_imm_ext << 2);
        case (opcode_f_id)
            c_OP_ADD:  w_alu = rs_reg_value_f_id + rt_reg_value_f_id;
            c_OP_ADDI: w_alu = rs_reg_value_f_id + i_data_f_id;
            c_OP_SUB:  w_alu = rs_reg_value_f_id - rt_reg_value_f_id;
            c_OP_SUBI: w_alu = rs_reg_value_f_id - i_data_f_id;
            c_OP_MUL:  w_alu = rs_reg_value_f_id * rt_reg_value_f_id;
            c_OP_MULI: w_alu = rs_reg_value_f_id * i_data_f_id;
            c_OP_OR:   w_alu = rs_reg_value_f_id | rt_reg_value_f_id;
            c_OP_ORI:  w_alu = rs_reg_value_f_id | i_data_f_id;
            c_OP_AND:  w_alu = rs_reg_value_f_id & rt_reg_value_f_id;
            c_OP_ANDI: w_alu = rs_reg_value_f_id & i_data_f_id;
            c_OP_XOR:  w_alu = rs_reg_value_f_id ^ rt_reg_value_f_id;
            c_OP_XORI: w_alu = rs_reg_value_f_id ^ i_data_f_id;
            c_OP_LDW:  w_alu = rs_reg_value_f_id + i_data_f_id;
            c_OP_STW:  w_alu = rs_reg_value_f_id + i_data_f_id;
            c_OP_BZ:   w_taken_cond = (rs_reg_value_f_id == '0);
            c_OP_BEQ:  w_taken_cond = (rs_reg_value_f_id == rt_reg_value_f_id);
            c_OP_JR: begin
                w_taken_cond = 1'b1;
                w_target     = 32'(rs_reg_value_f_id);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_RUN;
            r_shadow_cnt <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow_cnt <= w_shadow_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (w_taken && (c_SHADOW != 2'd0)) begin
                    w_state_nxt  = c_ST_SQUASH;
                    w_shadow_nxt = c_SHADOW;
                end else if (w_is_halt) begin
                    w_state_nxt  = c_ST_HALTED;
                end
            end
            c_ST_SQUASH: begin
                // The input consumed this cycle is the last shadow slot when count is 1.
                if (r_shadow_cnt <= 2'd1) begin
                    w_state_nxt  = c_ST_RUN;
                    w_shadow_nxt = 2'd0;
                end else begin
                    w_shadow_nxt = r_shadow_cnt - 2'd1;
                end
            end
            c_ST_HALTED: ;
            default: begin
                w_state_nxt  = c_ST_RUN;
                w_shadow_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_rd_add        <= '0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_halt          <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_alu_result   <= w_exec ? w_alu : '0;
            r_store_data   <= w_exec ? rt_reg_value_f_id : '0;
            r_rd_add       <= w_exec ? rd_add_value_f_id : '0;
            r_reg_write    <= w_exec && mem_to_reg_f_id;
            r_mem_read     <= w_exec && mem_read_f_id;
            r_mem_write    <= w_exec && mem_write_f_id;
            r_halt         <= r_halt || w_is_halt;
            r_branch_taken <= w_taken;
            if (w_taken) begin
                r_branch_target <= w_target;
            end
        end
    end

    assign alu_result_2_mem   = r_alu_result;
    assign store_data_2_mem   = r_store_data;
    assign rd_add_2_mem       = r_rd_add;
    assign reg_write_2_mem    = r_reg_write;
    assign mem_read_2_mem     = r_mem_read;
    assign mem_write_2_mem    = r_mem_write;
    assign halt_2_mem         = r_halt;
    assign branch_taken_2_if  = r_branch_taken;
    assign branch_target_2_if = r_branch_target;

`ifdef EX_PERF_CNT_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_taken_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired_cnt <= '0;
            r_taken_cnt   <= '0;
        end else begin
            if (w_exec || w_is_halt) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign taken_cnt   = r_taken_cnt;
`else
    assign retired_cnt = '0;
    assign taken_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_stage
// Directed bench for ex_stage with an instruction-level reference model.
// Rev     : 1.0
// ============================================================================
module tb_ex_stage;

    localparam int c_SHADOW = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc4;
    logic [5:0]  opcode;
    logic [31:0] rs_v, rt_v, imm_v;
    logic [4:0]  rd_v;
    logic        br_f, mr_f, m2r_f, mw_f;
    logic [31:0] alu, st, tgt, ret, tkn;
    logic [4:0]  rd_o;
    logic        rw, mr, mw, halt, br;

    ex_stage #(.D_SIZE(32), .ADDR_LINE_REG(5), .BRANCH_SHADOW(c_SHADOW)) dut (
        .clk(clk), .reset(reset), .pc4_in_f_id(pc4), .opcode_f_id(opcode),
        .rs_reg_value_f_id(rs_v), .rt_reg_value_f_id(rt_v), .rd_add_value_f_id(rd_v),
        .i_data_f_id(imm_v), .branch_f_id(br_f), .mem_read_f_id(mr_f),
        .mem_to_reg_f_id(m2r_f), .mem_write_f_id(mw_f),
        .alu_result_2_mem(alu), .store_data_2_mem(st), .rd_add_2_mem(rd_o),
        .reg_write_2_mem(rw), .mem_read_2_mem(mr), .mem_write_2_mem(mw),
        .halt_2_mem(halt), .branch_taken_2_if(br), .branch_target_2_if(tgt),
        .retired_cnt(ret), .taken_cnt(tkn)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] e_alu, e_st, e_tgt, e_ret, e_tkn;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw, e_halt, e_br;
    bit          e_dc_alu, e_dc_tgt;

    int          m_shadow;
    bit          m_halted;
    logic [31:0] m_ret, m_tkn, m_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_view(input logic [31:0] v);
`ifdef EX_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic clear_exp();
        e_alu = '0; e_st = '0; e_rd = '0;
        e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_br = 1'b0;
        e_dc_alu = 1'b0; e_dc_tgt = 1'b0;
    endtask

    task automatic model_reset();
        m_shadow = 0; m_halted = 1'b0;
        m_ret = '0; m_tkn = '0; m_tgt = '0;
        clear_exp();
        e_halt = 1'b0; e_tgt = '0; e_ret = '0; e_tkn = '0;
    endtask

    task automatic drive_nop();
        opcode = 6'h3F; rs_v = '0; rt_v = '0; imm_v = '0; rd_v = '0; pc4 = '0;
        br_f = 1'b0; mr_f = 1'b0; m2r_f = 1'b0; mw_f = 1'b0;
    endtask

    // One instruction per cycle; the model predicts what appears after the next edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] rd = '0, input bit m2r = 0,
                         input bit mrd = 0, input bit mwr = 0, input logic [31:0] pc = '0);
        bit taken;
        @(negedge clk);
        opcode = op; rs_v = rs; rt_v = rt; imm_v = imm; rd_v = rd; pc4 = pc;
        br_f = (op >= 6'h0E && op <= 6'h10); mr_f = mrd; m2r_f = m2r; mw_f = mwr;
        clear_exp();
        if (m_halted) begin
        end else if (m_shadow > 0) begin
            m_shadow--;
        end else if (op == 6'h11) begin
            m_halted = 1'b1;
            m_ret++;
        end else if (op <= 6'h10) begin
            m_ret++;
            e_st = rt; e_rd = rd; e_rw = m2r; e_mr = mrd; e_mw = mwr;
            case (op)
                6'h00: e_alu = rs + rt;
                6'h01: e_alu = rs + imm;
                6'h02: e_alu = rs - rt;
                6'h03: e_alu = rs - imm;
                6'h04: e_alu = rs * rt;
                6'h05: e_alu = rs * imm;
                6'h06: e_alu = rs | rt;
                6'h07: e_alu = rs | imm;
                6'h08: e_alu = rs & rt;
                6'h09: e_alu = rs & imm;
                6'h0A: e_alu = rs ^ rt;
                6'h0B: e_alu = rs ^ imm;
                6'h0C, 6'h0D: e_alu = rs + imm;
                default: begin
                    e_dc_alu = 1'b1;
                    taken = (op == 6'h0E) ? (rs == 0) : (op == 6'h0F) ? (rs == rt) : 1'b1;
                    if (taken) begin
                        e_br = 1'b1;
                        m_tkn++;
                        m_tgt = (op == 6'h10) ? rs : pc + imm * 4;
                        m_shadow = c_SHADOW;
                    end else begin
                        e_dc_tgt = 1'b1;
                    end
                end
            endcase
        end
        e_halt = m_halted; e_tgt = m_tgt;
        e_ret = cnt_view(m_ret); e_tkn = cnt_view(m_tkn);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_nop();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!e_dc_alu) begin
            chk("alu_result", alu, e_alu);
            chk("rd_add", 32'(rd_o), 32'(e_rd));
        end
        chk("store_data", st, e_st);
        chk("reg_write", 32'(rw), 32'(e_rw));
        chk("mem_read", 32'(mr), 32'(e_mr));
        chk("mem_write", 32'(mw), 32'(e_mw));
        chk("halt", 32'(halt), 32'(e_halt));
        chk("branch_taken", 32'(br), 32'(e_br));
        if (!e_dc_tgt) chk("branch_target", tgt, e_tgt);
        chk("retired_cnt", ret, e_ret);
        chk("taken_cnt", tkn, e_tkn);
    end

    initial begin
        reset = 1'b1;
        drive_nop();
        model_reset();
        #1;
        chk("reset alu", alu, 32'h0);
        chk("reset halt", 32'(halt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        issue(6'h00, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd5, 1);
        settle();
        chk("ADD alu lit", alu, 32'h0000_0001);
        chk("ADD rd lit", 32'(rd_o), 32'd5);
        chk("ADD rw lit", 32'(rw), 32'd1);

        issue(6'h05, 32'h0001_0000, 32'd0, 32'hFFFF_FFFF);
        settle();
        chk("MULI lit", alu, 32'hFFFF_0000);

        issue(6'h0D, 32'h100, 32'hAB, 32'd8, 5'd0, 0, 0, 1);
        settle();
        chk("STW addr lit", alu, 32'h108);
        chk("STW data lit", st, 32'hAB);
        chk("STW mw lit", 32'(mw), 32'd1);

        for (int op = 0; op <= 12; op++)
            issue(6'(op), 32'h1234_5678, 32'h0F0F_00FF, 32'hFFFF_FFF0, 5'(op), 1, (op == 12), 0);

        issue(6'h0F, 32'd7, 32'd7, 32'd3, 5'd0, 0, 0, 0, 32'h40);
        settle();
        chk("BEQ pulse lit", 32'(br), 32'd1);
        chk("BEQ target lit", tgt, 32'h4C);
        issue(6'h00, 32'd1, 32'd1, 32'd0, 5'd3, 1);
        settle();
        chk("shadow rw lit", 32'(rw), 32'd0);
        chk("shadow pulse lit", 32'(br), 32'd0);
        issue(6'h00, 32'd1, 32'd1, 32'd0, 5'd3, 1);
        settle();
        chk("post-shadow ADD lit", alu, 32'd2);

        issue(6'h0E, 32'd1, 32'd0, 32'd5, 5'd0, 0, 0, 0, 32'h80);
        settle();
        chk("BZ not-taken lit", 32'(br), 32'd0);
        issue(6'h01, 32'd10, 32'd0, 32'd5, 5'd1, 1);
        settle();
        chk("no squash after BZ lit", alu, 32'd15);

        issue(6'h0E, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 0, 0, 0, 32'h100);
        settle();
        chk("BZ back target lit", tgt, 32'hFC);
        issue(6'h3F, 32'd0, 32'd0, 32'd0);

        issue(6'h10, 32'h200, 32'd0, 32'd0);
        settle();
        chk("JR target lit", tgt, 32'h200);
        issue(6'h11, 32'd0, 32'd0, 32'd0);
        settle();
        chk("squashed HALT lit", 32'(halt), 32'd0);
        issue(6'h02, 32'd9, 32'd4, 32'd0, 5'd4, 1);
        settle();
        chk("SUB lit", alu, 32'd5);
        issue(6'h3F, 32'd5, 32'd5, 32'd5, 5'd5, 1);
        issue(6'h20, 32'd5, 32'd5, 32'd5, 5'd5, 1, 1, 1);

        do_reset();
        issue(6'h00, 32'd1, 32'd2, 32'd0, 5'd1, 1);
        issue(6'h0F, 32'd3, 32'd3, 32'd1, 5'd0, 0, 0, 0, 32'h10);
        issue(6'h02, 32'd8, 32'd1, 32'd0, 5'd2, 1);
        issue(6'h3F, 32'd0, 32'd0, 32'd0);
        issue(6'h11, 32'd0, 32'd0, 32'd0);
        settle();
        chk("HALT lit", 32'(halt), 32'd1);
`ifdef EX_PERF_CNT_EN
        chk("retired lit", ret, 32'd3);
        chk("taken lit", tkn, 32'd1);
`else
        chk("retired tied lit", ret, 32'd0);
        chk("taken tied lit", tkn, 32'd0);
`endif
        issue(6'h00, 32'd1, 32'd1, 32'd0, 5'd2, 1);
        settle();
        chk("halted rw lit", 32'(rw), 32'd0);
        issue(6'h0D, 32'h10, 32'h5, 32'd4, 5'd0, 0, 0, 1);
        settle();
        chk("halted mw lit", 32'(mw), 32'd0);
        chk("halt sticky lit", 32'(halt), 32'd1);

        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async reset halt lit", 32'(halt), 32'd0);
        chk("async reset tgt lit", tgt, 32'd0);
        drive_nop();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(6'h00, 32'd20, 32'd22, 32'd0, 5'd7, 1);
        settle();
        chk("post-reset ADD lit", alu, 32'd42);
        chk("post-reset rw lit", 32'(rw), 32'd1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
